// File: rtl/run_sequencer.sv
// Run sequencer: preloads the core data memory, holds the core in reset for a
// fixed number of cycles, then times the run until Done or a cycle-limit timeout.
module run_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             LdValid,
  input  logic [7:0]       LdAddr,
  input  logic [7:0]       LdData,
  input  logic             LdLast,
  output logic             LdReady,
  output logic             MemWen,
  output logic [7:0]       MemAddr,
  output logic [7:0]       MemWdat,
  input  logic             ProgDone,
  output logic             CoreReset,
  output logic             Busy,
  output logic             Finished,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CORE_RST = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4,
    S_TIMEOUT  = 3'd5
  } state_t;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           state;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] next_count;

  assign dbg_state  = state;
  assign next_count = CycleCount + CNT_W'(1);

  // Load port handshake: a word transfers on any rising edge where LdValid and
  // LdReady are both high; LdReady is high for the whole LOAD state and the
  // memory write strobe is LdValid passed straight through, so the write lands
  // on that same edge. LdLast only counts when it rides on a transferring word.
  assign MemWen  = (state == S_LOAD) && LdValid;
  assign MemAddr = (state == S_LOAD) ? LdAddr : 8'd0;
  assign MemWdat = (state == S_LOAD) ? LdData : 8'd0;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      rst_cnt    <= '0;
      CoreReset  <= 1'b1;
      Busy       <= 1'b0;
      Finished   <= 1'b0;
      TimedOut   <= 1'b0;
      CycleCount <= '0;
      LdReady    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (Start) begin
            state      <= S_LOAD;
            LdReady    <= 1'b1;
            Busy       <= 1'b1;
            Finished   <= 1'b0;
            TimedOut   <= 1'b0;
            CycleCount <= '0;
          end
        end
        S_LOAD: begin
          if (LdValid && LdLast) begin
            state   <= S_CORE_RST;
            LdReady <= 1'b0;
            rst_cnt <= RW'(RST_CYCLES - 1);
          end
        end
        S_CORE_RST: begin
          // rst_cnt counts the remaining hold cycles after the current one
          if (rst_cnt == '0) begin
            state     <= S_RUN;
            CoreReset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        S_RUN: begin
          CycleCount <= next_count;
          if (ProgDone) begin
            state     <= S_DONE;
            Finished  <= 1'b1;
            Busy      <= 1'b0;
            CoreReset <= 1'b1;
          end else if (next_count == CNT_W'(MAX_CYCLES)) begin
            state     <= S_TIMEOUT;
            TimedOut  <= 1'b1;
            Busy      <= 1'b0;
            CoreReset <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          CoreReset <= 1'b1;
          Busy      <= 1'b0;
          LdReady   <= 1'b0;
        end
      endcase
    end
  end

endmodule
